// File: rtl/regfile_wr_arbiter_if.sv
// Bundle of the two requester handshakes and the register-file write port.
// The arbiter connects through the slave modport; the requester/regfile side uses master.
interface regfile_wr_arbiter_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
);
  logic              A_req;
  logic [ADDR_W-1:0] A_addr;
  logic [DATA_W-1:0] A_data;
  logic              B_req;
  logic [ADDR_W-1:0] B_addr;
  logic [DATA_W-1:0] B_data;
  logic              A_gnt;
  logic              B_gnt;
  logic              WE;
  logic [ADDR_W-1:0] WR_addr;
  logic [DATA_W-1:0] WR_data;

  modport master (
    output A_req, A_addr, A_data, B_req, B_addr, B_data,
    input  A_gnt, B_gnt, WE, WR_addr, WR_data
  );

  modport slave (
    input  A_req, A_addr, A_data, B_req, B_addr, B_data,
    output A_gnt, B_gnt, WE, WR_addr, WR_data
  );
endinterface

// File: rtl/regfile_wr_arbiter.sv
// Two-requester write arbiter driving one register-file write port, with write counter and dirty map.
// Optional macro ARB_FIXED_PRIO_EN: A wins every idle tie and the round-robin pointer is removed.
module regfile_wr_arbiter #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  regfile_wr_arbiter_if.slave    bus,
  output logic [7:0]             wr_count,
  output logic [(1<<ADDR_W)-1:0] dirty
);
  localparam int NREG = 1 << ADDR_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WR_A = 2'd1,
    WR_B = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic              w_tie_b;
  logic              w_we;
  logic              w_a_gnt;
  logic              w_b_gnt;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [DATA_W-1:0] r_wr_data;
  logic [7:0]        r_wr_count;
  logic [NREG-1:0]   r_dirty;

`ifdef ARB_FIXED_PRIO_EN
  assign w_tie_b = 1'b0;
`else
  logic r_prefer_b;

  // Every grant hands preference to the side that was not granted.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_prefer_b <= 1'b0;
    end else if (w_state_next == WR_A) begin
      r_prefer_b <= 1'b1;
    end else if (w_state_next == WR_B) begin
      r_prefer_b <= 1'b0;
    end
  end

  assign w_tie_b = r_prefer_b;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // The requester being served is never re-examined at the edge closing its own grant.
  always_comb begin
    w_state_next = r_state;
    w_a_gnt      = 1'b0;
    w_b_gnt      = 1'b0;
    w_we         = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.A_req && bus.B_req) begin
          w_state_next = w_tie_b ? WR_B : WR_A;
        end else if (bus.A_req) begin
          w_state_next = WR_A;
        end else if (bus.B_req) begin
          w_state_next = WR_B;
        end else begin
          w_state_next = IDLE;
        end
      end
      WR_A: begin
        w_a_gnt      = 1'b1;
        w_we         = 1'b1;
        w_state_next = bus.B_req ? WR_B : IDLE;
      end
      WR_B: begin
        w_b_gnt      = 1'b1;
        w_we         = 1'b1;
        w_state_next = bus.A_req ? WR_A : IDLE;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // Write port is loaded on entry to a grant state and holds otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_addr <= '0;
      r_wr_data <= '0;
    end else if (w_state_next == WR_A) begin
      r_wr_addr <= bus.A_addr;
      r_wr_data <= bus.A_data;
    end else if (w_state_next == WR_B) begin
      r_wr_addr <= bus.B_addr;
      r_wr_data <= bus.B_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_count <= 8'd0;
    end else if (w_we) begin
      r_wr_count <= r_wr_count + 8'd1;
    end
  end

  generate
    for (genvar gi = 0; gi < NREG; gi++) begin : g_dirty
      always_ff @(posedge clk) begin
        if (rst) begin
          r_dirty[gi] <= 1'b0;
        end else if (w_we && (r_wr_addr == ADDR_W'(gi))) begin
          r_dirty[gi] <= 1'b1;
        end
      end
    end
  endgenerate

  assign bus.A_gnt   = w_a_gnt;
  assign bus.B_gnt   = w_b_gnt;
  assign bus.WE      = w_we;
  assign bus.WR_addr = r_wr_addr;
  assign bus.WR_data = r_wr_data;
  assign wr_count    = r_wr_count;
  assign dirty       = r_dirty;
endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Directed and randomized bench for regfile_wr_arbiter against a grant-level reference model.
// Requesters follow the hold-until-grant, drop-next-cycle protocol.
module tb_regfile_wr_arbiter;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 3;
  localparam int NREG   = 8;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [7:0]      wr_count;
  logic [NREG-1:0] dirty;

  regfile_wr_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  regfile_wr_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .wr_count (wr_count),
    .dirty    (dirty)
  );

  always #5 clk = ~clk;

  // Register file fed by the DUT write port.
  logic [DATA_W-1:0] rf [NREG];
  always @(posedge clk) begin
    if (bus.WE === 1'b1) rf[bus.WR_addr] <= bus.WR_data;
  end

  int errors = 0;
  int checks = 0;

  // Reference model: grant in progress (0 none, 1 A, 2 B) and the architectural results.
  int          m_gnt = 0;
  bit          m_ptr_b = 1'b0;
  logic [7:0]  m_cnt = 8'd0;
  logic [7:0]  m_dirty = 8'd0;
  logic [2:0]  m_addr = 3'd0;
  logic [15:0] m_data = 16'd0;
  logic [15:0] m_mem [NREG];
  bit          m_valid [NREG];
  int          grants[$];

  // Requester behaviour knobs.
  int          a_prob = 0, b_prob = 0;
  bit          a_rand = 1'b0, b_rand = 1'b0;
  logic [2:0]  a_fix_addr = 3'd0, b_fix_addr = 3'd0;
  logic [15:0] a_fix_data = 16'd0, b_fix_data = 16'd0;
  bit          a_drop = 1'b0, b_drop = 1'b0;
  bit          fixed_prio;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance the model across the coming clock edge using the inputs currently applied.
  task automatic model_update();
    int g_next;
    if (m_gnt != 0) begin
      m_mem[m_addr]   = m_data;
      m_valid[m_addr] = 1'b1;
      if (!rst) begin
        m_cnt = m_cnt + 8'd1;
        m_dirty[m_addr] = 1'b1;
      end
    end
    if (rst) begin
      g_next  = 0;
      m_ptr_b = 1'b0;
      m_addr  = 3'd0;
      m_data  = 16'd0;
      m_cnt   = 8'd0;
      m_dirty = 8'd0;
    end else begin
      if (m_gnt == 1)      g_next = bus.B_req ? 2 : 0;
      else if (m_gnt == 2) g_next = bus.A_req ? 1 : 0;
      else if (bus.A_req && bus.B_req) g_next = (fixed_prio || !m_ptr_b) ? 1 : 2;
      else if (bus.A_req)  g_next = 1;
      else if (bus.B_req)  g_next = 2;
      else                 g_next = 0;
      if (g_next == 1) begin
        m_addr = bus.A_addr; m_data = bus.A_data; m_ptr_b = 1'b1;
      end else if (g_next == 2) begin
        m_addr = bus.B_addr; m_data = bus.B_data; m_ptr_b = 1'b0;
      end
      if (g_next != 0) grants.push_back(g_next);
    end
    m_gnt = g_next;
  endtask

  task automatic drive_req();
    if (m_gnt == 1) a_drop = 1'b1;
    else if (a_drop) begin
      bus.A_req = 1'b0; a_drop = 1'b0;
    end else if (!bus.A_req && ($urandom_range(1, 100) <= a_prob)) begin
      bus.A_req  = 1'b1;
      bus.A_addr = a_rand ? 3'($urandom) : a_fix_addr;
      bus.A_data = a_rand ? 16'($urandom) : a_fix_data;
    end
    if (m_gnt == 2) b_drop = 1'b1;
    else if (b_drop) begin
      bus.B_req = 1'b0; b_drop = 1'b0;
    end else if (!bus.B_req && ($urandom_range(1, 100) <= b_prob)) begin
      bus.B_req  = 1'b1;
      bus.B_addr = b_rand ? 3'($urandom) : b_fix_addr;
      bus.B_data = b_rand ? 16'($urandom) : b_fix_data;
    end
  endtask

  task automatic step();
    model_update();
    @(posedge clk);
    #1;
    chk("WE", 32'(bus.WE), 32'(m_gnt != 0));
    chk("A_gnt", 32'(bus.A_gnt), 32'(m_gnt == 1));
    chk("B_gnt", 32'(bus.B_gnt), 32'(m_gnt == 2));
    chk("WR_addr", 32'(bus.WR_addr), 32'(m_addr));
    chk("WR_data", 32'(bus.WR_data), 32'(m_data));
    chk("wr_count", 32'(wr_count), 32'(m_cnt));
    chk("dirty", 32'(dirty), 32'(m_dirty));
    for (int i = 0; i < NREG; i++) begin
      if (m_valid[i]) chk($sformatf("rf[%0d]", i), 32'(rf[i]), 32'(m_mem[i]));
    end
    if (m_gnt != 0)
      $display("txn t=%0t side=%s addr=%0d data=0x%04h", $time, (m_gnt == 1) ? "A" : "B", m_addr, m_data);
    drive_req();
  endtask

  task automatic do_reset();
    a_prob = 0; b_prob = 0; a_rand = 1'b0; b_rand = 1'b0;
    bus.A_req = 1'b0; bus.B_req = 1'b0; a_drop = 1'b0; b_drop = 1'b0;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    step();
    grants.delete();
  endtask

  initial begin
`ifdef ARB_FIXED_PRIO_EN
    fixed_prio = 1'b1;
`else
    fixed_prio = 1'b0;
`endif
    for (int i = 0; i < NREG; i++) begin
      m_valid[i] = 1'b0;
      m_mem[i]   = 16'd0;
    end
    bus.A_req = 1'b0; bus.A_addr = 3'd0; bus.A_data = 16'd0;
    bus.B_req = 1'b0; bus.B_addr = 3'd0; bus.B_data = 16'd0;

    // Reset state after two reset cycles and an idle cycle.
    do_reset();
    chk("rst_WE", 32'(bus.WE), 32'd0);
    chk("rst_gnt", 32'({bus.A_gnt, bus.B_gnt}), 32'd0);
    chk("rst_addr", 32'(bus.WR_addr), 32'd0);
    chk("rst_data", 32'(bus.WR_data), 32'd0);
    chk("rst_cnt", 32'(wr_count), 32'd0);
    chk("rst_dirty", 32'(dirty), 32'h00);

    // Single A write, one-cycle latency.
    a_fix_addr = 3'd0; a_fix_data = 16'hABCD; a_prob = 100;
    step();
    a_prob = 0;
    step();
    chk("single_WE", 32'(bus.WE), 32'd1);
    chk("single_A_gnt", 32'(bus.A_gnt), 32'd1);
    chk("single_addr", 32'(bus.WR_addr), 32'd0);
    chk("single_data", 32'(bus.WR_data), 32'hABCD);
    step();
    chk("single_cnt", 32'(wr_count), 32'd1);
    chk("single_dirty", 32'(dirty), 32'h01);
    step();

    // Dual requesters re-requesting: A,B,A,B.
    do_reset();
    a_fix_addr = 3'd1; a_fix_data = 16'h0123; b_fix_addr = 3'd2; b_fix_data = 16'h4567;
    a_prob = 100; b_prob = 100;
    for (int i = 0; i < 40 && grants.size() < 4; i++) step();
    a_prob = 0; b_prob = 0;
    chk("dual_ngrants", 32'(grants.size()), 32'd4);
    if (grants.size() >= 4) begin
      chk("dual_g0", 32'(grants[0]), 32'd1);
      chk("dual_g1", 32'(grants[1]), 32'd2);
      chk("dual_g2", 32'(grants[2]), 32'd1);
      chk("dual_g3", 32'(grants[3]), 32'd2);
    end
    repeat (3) step();
    chk("dual_cnt", 32'(wr_count), 32'd4);
    chk("dual_dirty", 32'(dirty), 32'h06);

    // Same-address collision after an A grant (pointer now prefers B).
    do_reset();
    a_fix_addr = 3'd3; a_fix_data = 16'h3333; a_prob = 100;
    step();
    a_prob = 0;
    repeat (4) step();
    grants.delete();
    a_fix_addr = 3'd5; a_fix_data = 16'h1111; b_fix_addr = 3'd5; b_fix_data = 16'h2222;
    a_prob = 100; b_prob = 100;
    step();
    a_prob = 0; b_prob = 0;
    repeat (6) step();
    chk("coll_ngrants", 32'(grants.size()), 32'd2);
    if (grants.size() >= 2) begin
      chk("coll_first", 32'(grants[0]), fixed_prio ? 32'd1 : 32'd2);
      chk("coll_second", 32'(grants[1]), fixed_prio ? 32'd2 : 32'd1);
    end
    chk("coll_rf5", 32'(rf[5]), fixed_prio ? 32'h2222 : 32'h1111);

    // Reset during WR_A with B pending aborts the B grant.
    do_reset();
    a_fix_addr = 3'd4; a_fix_data = 16'h4444; b_fix_addr = 3'd6; b_fix_data = 16'h6666;
    a_prob = 100; b_prob = 100;
    step();
    a_prob = 0; b_prob = 0;
    step();
    chk("abort_in_WR_A", 32'(bus.A_gnt), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_WE", 32'(bus.WE), 32'd0);
    chk("abort_B_gnt", 32'(bus.B_gnt), 32'd0);
    chk("abort_cnt", 32'(wr_count), 32'd0);
    chk("abort_dirty", 32'(dirty), 32'h00);
    repeat (6) step();

    // 256 single writes wrap the counter.
    do_reset();
    a_rand = 1'b1; a_prob = 100;
    for (int i = 0; i < 1200 && grants.size() < 256; i++) step();
    a_prob = 0;
    chk("wrap_ngrants", 32'(grants.size()), 32'd256);
    repeat (3) step();
    chk("wrap_cnt", 32'(wr_count), 32'd0);
    chk("wrap_dirty", 32'(dirty), 32'(m_dirty));

    // Randomized traffic with occasional resets.
    do_reset();
    a_rand = 1'b1; b_rand = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if (i % 200 == 0) begin
        a_prob = $urandom_range(10, 100);
        b_prob = $urandom_range(10, 100);
      end
      rst = ($urandom_range(0, 299) == 0);
      step();
    end
    rst = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/regfile_wr_arbiter.md
REGFILE_WR_ARBITER -- requirements
Module: regfile_wr_arbiter

Interface
REQ-001 Parameter DATA_W, default 16, SHALL set the write data width.
REQ-002 Parameter ADDR_W, default 3, SHALL set the register address width; register count is 2**ADDR_W.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on rising edge.
REQ-004 rst  input  1  SHALL be the reset: synchronous, active-high.
REQ-005 A_req  input  1  SHALL be requester A's write request; A_addr input ADDR_W and A_data input DATA_W are its target and payload.
REQ-006 B_req  input  1  SHALL be requester B's write request; B_addr input ADDR_W and B_data input DATA_W are its target and payload.
REQ-007 A_gnt, B_gnt  output  1 each  SHALL pulse high for the cycle the write is presented to the register file.
REQ-008 WE  output  1, WR_addr  output  ADDR_W, WR_data  output  DATA_W  SHALL drive the register file write port directly.
REQ-009 wr_count  output  8  SHALL count completed writes.
REQ-010 dirty  output  2**ADDR_W  SHALL flag each register written since reset.

Function
REQ-011 FSM SHALL have states IDLE, WR_A, WR_B; A_gnt=1 only in WR_A, B_gnt=1 only in WR_B, WE=1 only in WR_A or WR_B.
REQ-012 IDLE: A_req only -> WR_A; B_req only -> WR_B; both -> side selected by round-robin pointer; neither -> IDLE.
REQ-013 WR_A: B_req=1 -> WR_B, else -> IDLE; A_req is ignored at the edge closing WR_A.
REQ-014 WR_B: A_req=1 -> WR_A, else -> IDLE; B_req is ignored at the edge closing WR_B.
REQ-015 Requesters SHALL hold req/addr/data stable until they see gnt, then deassert req the next cycle; a held req gets exactly one write per grant.
REQ-016 Latency: a req sampled at edge N SHALL produce WE, gnt, WR_addr, WR_data in cycle N+1 (all registered, captured at edge N); in the WR_A/WR_B cases of REQ-013/014 the other side waits at most one cycle.
REQ-017 Round-robin pointer SHALL update on every grant to prefer the side not granted; sustained dual requests SHALL alternate A,B,A,B with one write per cycle.
REQ-018 When WE=0, WR_addr and WR_data SHALL hold their last values.
REQ-019 wr_count SHALL increment by 1 at every edge closing a cycle with WE=1 and wrap 255 -> 0.
REQ-020 dirty[WR_addr] SHALL set at the edge closing a cycle with WE=1 and never clear except by rst.
REQ-021 Both requesters targeting the same address SHALL both be written in grant order; the register file holds the later data.

Reset
REQ-022 rst SHALL override all other inputs at the edge it is sampled; requests present during rst are discarded.
REQ-023 After rst: state IDLE, WE=0, A_gnt=0, B_gnt=0, WR_addr=0, WR_data=0, wr_count=0, dirty=0, pointer preferring A.
REQ-024 rst asserted during WR_A/WR_B SHALL abort the next grant; the write presented in the current cycle completes at the register file.

Configuration
REQ-025 Macro ARB_FIXED_PRIO_EN, when defined, SHALL make A win every IDLE tie; the pointer is not implemented.
REQ-026 Without ARB_FIXED_PRIO_EN, IDLE ties SHALL follow the round-robin pointer per REQ-017.
REQ-027 REQ-013/014 alternation SHALL apply in both builds.

Verification
REQ-028 rst 2 cycles, then idle -> WE=0, gnt=0, WR_addr=0, WR_data=0, wr_count=0, dirty=8'h00.
REQ-029 A_req with A_addr=0, A_data=16'hABCD -> next cycle WE=1, A_gnt=1, WR_addr=0, WR_data=16'hABCD; afterwards dirty=8'h01, wr_count=1.
REQ-030 A and B request together for 4 cycles (A: addr 1, 16'h0123; B: addr 2, 16'h4567; each drops req after its gnt, then re-requests) -> grants A,B,A,B, wr_count=4, dirty=8'h06. With ARB_FIXED_PRIO_EN, the first grant is still A.
REQ-031 Simultaneous A and B to addr 5 with pointer preferring B -> B then A; final register 5 holds A_data.
REQ-032 rst pulsed in the WR_A cycle while B_req=1 -> no WR_B; IDLE, wr_count=0, dirty=0 next cycle.
REQ-033 256 single writes -> wr_count wraps to 0; dirty unchanged by the wrap.
